// File: rtl/cia_pkg.sv
// Shared constants and FSM state type for the b-vector serializer.
package cia_pkg;

    localparam int unsigned DEPTH  = 784;  // words per vector
    localparam int unsigned IDX_W  = 10;   // index / address width
    localparam int unsigned WORD_W = 24;   // sum width (three bytes)

    typedef enum logic [2:0] {
        COLLECT,
        RD,
        LOAD,
        EMIT,
        DONE
    } ser_state_t;

endpackage

// File: rtl/bram_sdp.sv
// Simple dual-port RAM: synchronous write on port A, registered read on port B.
// Ports: clk; we/waddr/wdata (write); re/raddr (read request); q (data, 1-cycle latency).
module bram_sdp #(
    parameter int unsigned WIDTH  = 24,
    parameter int unsigned DEPTH  = 784,
    parameter int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  q
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents are never reset; a fresh vector overwrites every word before it is read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            q <= mem[raddr];
        end
    end

endmodule

// File: rtl/b_serializer.sv
// Collects DEPTH 24-bit sums by index into RAM, then streams the vector out as bytes
// (MSB first, three per word) over a valid/ready byte port.
// Ports: clk_in/rst_in (async active-high); sum_valid/sum_in/sum_idx/sum_ready (sum beats,
// no hold upstream); byte_valid/byte_out/byte_last/byte_ready (byte stream);
// restart (start a new vector from DONE); done (vector fully sent); err (sticky: [0] order, [1] lost).
module b_serializer
    import cia_pkg::*;
#(
    parameter int unsigned DEPTH = cia_pkg::DEPTH,
    parameter int unsigned IDX_W = cia_pkg::IDX_W
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              sum_valid,
    input  logic [WORD_W-1:0] sum_in,
    input  logic [IDX_W-1:0]  sum_idx,
    output logic              sum_ready,
    output logic              byte_valid,
    output logic [7:0]        byte_out,
    output logic              byte_last,
    input  logic              byte_ready,
    input  logic              restart,
    output logic              done,
    output logic [1:0]        err
);

    localparam int unsigned    RAM_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    ser_state_t        state;
    ser_state_t        state_nxt;
    logic [IDX_W-1:0]  wr_cnt;
    logic [IDX_W-1:0]  rd_addr;
    logic [1:0]        byte_sel;
    logic [WORD_W-1:0] word_q;
    logic [WORD_W-1:0] ram_q;

    logic accept_c;
    logic order_err_c;
    logic lost_c;
    logic hs_c;
    logic word_end_c;

    // Beat qualification: only the expected index is stored; anything outside COLLECT is lost.
    assign accept_c    = (state == COLLECT) & sum_valid & (sum_idx == wr_cnt);
    assign order_err_c = (state == COLLECT) & sum_valid & (sum_idx != wr_cnt);
    assign lost_c      = (state != COLLECT) & sum_valid;
    assign hs_c        = (state == EMIT) & byte_ready;
    assign word_end_c  = hs_c & (byte_sel == 2'd2);

    bram_sdp #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH),
        .ADDR_W(RAM_AW)
    ) u_ram (
        .clk  (clk_in),
        .we   (accept_c),
        .waddr(RAM_AW'(sum_idx)),
        .wdata(sum_in),
        .re   (state == RD),
        .raddr(RAM_AW'(rd_addr)),
        .q    (ram_q)
    );

    // State register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (accept_c && (wr_cnt == LAST_IDX)) state_nxt = RD;
            RD:      state_nxt = LOAD;
            LOAD:    state_nxt = EMIT;
            EMIT:    if (word_end_c) state_nxt = (rd_addr == LAST_IDX) ? DONE : RD;
            DONE:    if (restart) state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    // Counters, output word register and sticky error flags
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_cnt   <= '0;
            rd_addr  <= '0;
            byte_sel <= '0;
            word_q   <= '0;
            err      <= '0;
        end else begin
            // wr_cnt parks at the last index so it never wraps when DEPTH == 2**IDX_W
            if (accept_c && (wr_cnt != LAST_IDX)) begin
                wr_cnt <= wr_cnt + IDX_W'(1);
            end
            if (state == LOAD) begin
                word_q   <= ram_q;
                byte_sel <= '0;
            end
            if (hs_c) begin
                if (byte_sel != 2'd2) begin
                    byte_sel <= byte_sel + 2'd1;
                end else if (rd_addr != LAST_IDX) begin
                    rd_addr <= rd_addr + IDX_W'(1);
                end
            end
            if ((state == DONE) && restart) begin
                wr_cnt  <= '0;
                rd_addr <= '0;
                err     <= {lost_c, 1'b0};
            end else begin
                err <= err | {lost_c, order_err_c};
            end
        end
    end

    assign sum_ready  = (state == COLLECT) & ~rst_in;
    assign byte_valid = (state == EMIT);
    assign done       = (state == DONE);
    assign byte_last  = (rd_addr == LAST_IDX) & (byte_sel == 2'd2) & byte_valid;

    // Byte select, MSB first
    always_comb begin
        byte_out = word_q[7:0];
        case (byte_sel)
            2'd0:    byte_out = word_q[23:16];
            2'd1:    byte_out = word_q[15:8];
            default: byte_out = word_q[7:0];
        endcase
    end

endmodule

// File: tb/tb_b_serializer.sv
// Directed bench for b_serializer with a 4-word vector.
module tb_b_serializer;

    localparam int unsigned IDX_W = 10;

    logic             clk_in;
    logic             rst_in;
    logic             sum_valid;
    logic [23:0]      sum_in;
    logic [IDX_W-1:0] sum_idx;
    logic             sum_ready;
    logic             byte_valid;
    logic [7:0]       byte_out;
    logic             byte_last;
    logic             byte_ready;
    logic             restart;
    logic             done;
    logic [1:0]       err;

    int checks   = 0;
    int failures = 0;

    logic [23:0] w [4];
    logic [7:0]  exp_b [12];

    b_serializer #(
        .DEPTH(4),
        .IDX_W(IDX_W)
    ) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .sum_valid (sum_valid),
        .sum_in    (sum_in),
        .sum_idx   (sum_idx),
        .sum_ready (sum_ready),
        .byte_valid(byte_valid),
        .byte_out  (byte_out),
        .byte_last (byte_last),
        .byte_ready(byte_ready),
        .restart   (restart),
        .done      (done),
        .err       (err)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_vec(input logic [23:0] a, input logic [23:0] b,
                           input logic [23:0] c, input logic [23:0] d);
        w[0] = a; w[1] = b; w[2] = c; w[3] = d;
        for (int k = 0; k < 12; k++) begin
            exp_b[k] = 8'(w[k / 3] >> (8 * (2 - (k % 3))));
        end
    endtask

    task automatic send_sum(input int idx, input logic [23:0] data);
        chk("sum_ready_before_beat", sum_ready, 1'b1);
        sum_valid = 1'b1;
        sum_idx   = IDX_W'(idx);
        sum_in    = data;
        step();
        sum_valid = 1'b0;
    endtask

    task automatic send_vec();
        for (int i = 0; i < 4; i++) send_sum(i, w[i]);
    endtask

    // Consume nbytes bytes, optionally toggling byte_ready and injecting a stray sum beat.
    task automatic drain(input bit tog, input int inj, input int nbytes);
        int n   = 0;
        int cyc = 0;
        bit injected = 1'b0;
        while (n < nbytes && cyc < 200) begin
            byte_ready = tog ? ((cyc % 2) == 0) : 1'b1;
            sum_valid  = 1'b0;
            if (!injected && n == inj && byte_valid) begin
                sum_valid = 1'b1;
                sum_in    = 24'h777777;
                sum_idx   = '0;
                injected  = 1'b1;
            end
            if (byte_valid) begin
                chk($sformatf("byte_out[%0d]", n), byte_out, exp_b[n]);
                chk($sformatf("byte_last[%0d]", n), byte_last, (n == 11));
                if (byte_ready) n++;
            end else begin
                chk("byte_last_idle", byte_last, 1'b0);
            end
            step();
            cyc++;
        end
        sum_valid  = 1'b0;
        byte_ready = 1'b0;
        chk("drain_byte_count", n, nbytes);
    endtask

    task automatic do_restart();
        chk("done_before_restart", done, 1'b1);
        restart = 1'b1;
        step();
        restart = 1'b0;
        chk("restart_sum_ready", sum_ready, 1'b1);
        chk("restart_done", done, 1'b0);
        chk("restart_err", err, 2'b00);
    endtask

    initial begin
        rst_in     = 1'b0;
        sum_valid  = 1'b0;
        sum_in     = '0;
        sum_idx    = '0;
        byte_ready = 1'b0;
        restart    = 1'b0;

        // 1: asynchronous reset mid-cycle, then release
        step();
        step();
        #3 rst_in = 1'b1;
        #1;
        chk("rst_sum_ready", sum_ready, 1'b0);
        chk("rst_byte_valid", byte_valid, 1'b0);
        chk("rst_byte_last", byte_last, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 2'b00);
        step();
        rst_in = 1'b0;
        step();
        chk("rel_sum_ready", sum_ready, 1'b1);
        chk("rel_err", err, 2'b00);
        chk("rel_byte_valid", byte_valid, 1'b0);

        // 2: full vector, byte_ready held high, with latency check
        set_vec(24'h123456, 24'hABCDEF, 24'h000001, 24'hFFFFFF);
        send_vec();
        chk("lat_rd_sum_ready", sum_ready, 1'b0);
        chk("lat_rd_valid", byte_valid, 1'b0);
        step();
        chk("lat_load_valid", byte_valid, 1'b0);
        step();
        chk("lat_emit_valid", byte_valid, 1'b1);
        drain(1'b0, -1, 12);
        chk("t2_done", done, 1'b1);
        chk("t2_valid_after", byte_valid, 1'b0);
        chk("t2_err", err, 2'b00);
        do_restart();

        // 3: same vector with byte_ready toggling
        send_vec();
        drain(1'b1, -1, 12);
        chk("t3_done", done, 1'b1);
        do_restart();

        // 4: out-of-order index is dropped, then the correct sequence resumes
        set_vec(24'h123456, 24'hABCDEF, 24'h111213, 24'hFFFFFF);
        send_sum(0, w[0]);
        send_sum(2, 24'h0A0B0C);
        chk("t4_err_order", err, 2'b01);
        chk("t4_still_collect", sum_ready, 1'b1);
        send_sum(1, w[1]);
        send_sum(2, w[2]);
        send_sum(3, w[3]);
        drain(1'b0, -1, 12);
        chk("t4_done", done, 1'b1);
        chk("t4_err_sticky", err, 2'b01);
        do_restart();

        // 5: stray beat during EMIT is lost, stream unaffected
        set_vec(24'h123456, 24'hABCDEF, 24'h000001, 24'hFFFFFF);
        send_vec();
        drain(1'b0, 6, 12);
        chk("t5_done", done, 1'b1);
        chk("t5_err_lost", err, 2'b10);
        do_restart();

        // 6: reset while emitting byte 5, then a fresh vector
        send_vec();
        drain(1'b0, -1, 4);
        chk("t6_valid_before_rst", byte_valid, 1'b1);
        #3 rst_in = 1'b1;
        #1;
        chk("t6_rst_valid", byte_valid, 1'b0);
        chk("t6_rst_last", byte_last, 1'b0);
        chk("t6_rst_sum_ready", sum_ready, 1'b0);
        chk("t6_rst_done", done, 1'b0);
        step();
        rst_in = 1'b0;
        step();
        chk("t6_rel_sum_ready", sum_ready, 1'b1);
        chk("t6_rel_err", err, 2'b00);
        set_vec(24'h010203, 24'h040506, 24'h070809, 24'h0A0B0C);
        send_vec();
        drain(1'b1, -1, 12);
        chk("t6_done", done, 1'b1);
        chk("t6_err", err, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
